// File: rtl/hps_frame_reader_if.sv
// HPS frame reader bus: HPS PIO request/ack lines plus SDRAM read FIFO 1 port.
//
// Handshake: the HPS side asks for a word by toggling i_hps_req (either edge
// counts as one request). The reader answers with o_fifo_rd for one cycle,
// latches the FIFO word into o_word/o_row/o_col, and only then toggles o_ack.
// Software may read o_word/o_row/o_col once it sees o_ack differ from the
// value it last observed. At most one request may be outstanding beyond the
// one in service; a further request is dropped and flagged on o_overrun.
interface hps_frame_reader_if;
   logic        i_hps_start;
   logic        i_hps_req;
   logic [15:0] i_fifo_rdata;
   logic        o_fifo_rd;
   logic [15:0] o_word;
   logic [8:0]  o_row;
   logic [5:0]  o_col;
   logic        o_ack;
   logic        o_busy;
   logic        o_done;
   logic        o_overrun;
   logic [2:0]  o_state;

   // Driver side (HPS bridge / FIFO model).
   modport master (
      output i_hps_start, i_hps_req, i_fifo_rdata,
      input  o_fifo_rd, o_word, o_row, o_col, o_ack,
      input  o_busy, o_done, o_overrun, o_state
   );

   // Reader side.
   modport slave (
      input  i_hps_start, i_hps_req, i_fifo_rdata,
      output o_fifo_rd, o_word, o_row, o_col, o_ack,
      output o_busy, o_done, o_overrun, o_state
   );
endinterface

// File: rtl/hps_frame_reader.sv
// CLOCK_50-domain bridge from SDRAM read FIFO 1 (16 packed 1-bpp pixels per
// word) to the HPS PIO. Each HPS request toggle becomes one FIFO read strobe;
// the word is latched with its row/column address and acknowledged by a
// toggle, so software walks one frame with no lost or duplicated words.
module hps_frame_reader #(
   parameter int WORDS_PER_ROW = 40,
   parameter int ROWS          = 480,
   parameter int RD_LAT        = 1,
   parameter int SYNC_STAGES   = 2
) (
   input logic               CLOCK_50,
   input logic               DLY_RST_1,
   hps_frame_reader_if.slave bus
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_REQ  = 3'd1;
   localparam logic [2:0] FETCH     = 3'd2;
   localparam logic [2:0] WAIT_DATA = 3'd3;
   localparam logic [2:0] LATCH     = 3'd4;
   localparam logic [2:0] ACK       = 3'd5;
   localparam logic [2:0] DONE      = 3'd6;

   localparam logic [5:0] COL_LAST = 6'(WORDS_PER_ROW - 1);
   localparam logic [8:0] ROW_LAST = 9'(ROWS - 1);
   localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

   logic [SYNC_STAGES-1:0] start_sync;
   logic [SYNC_STAGES-1:0] req_sync;
   logic                   start_prev;
   logic                   req_prev;
   logic                   start_s;
   logic                   req_s;
   logic                   start_rise;
   logic                   start_fall;
   logic                   req_evt;

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic        pending;
   logic        pend_nxt;
   logic        ovr_set;
   logic        abort;
   logic        do_latch;
   logic        do_ack;
   logic        last_word;
   logic        do_last;
   logic [1:0]  lat_cnt;

   logic [8:0]  row_cnt;
   logic [5:0]  col_cnt;
   logic [15:0] word_q;
   logic [8:0]  row_q;
   logic [5:0]  col_q;
   logic        ack_q;
   logic        busy_q;
   logic        done_q;
   logic        overrun_q;

   assign start_s    = start_sync[SYNC_STAGES-1];
   assign req_s      = req_sync[SYNC_STAGES-1];
   assign start_rise = start_s & ~start_prev;
   assign start_fall = ~start_s & start_prev;
   assign req_evt    = req_s ^ req_prev;

   // Abort only matters while a frame is in progress; DONE keeps its result.
   assign abort     = start_fall && (state != IDLE) && (state != DONE);
   assign do_latch  = (state == LATCH) && !start_rise && !abort;
   assign do_ack    = (state == ACK) && !start_rise && !abort;
   assign last_word = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign do_last   = do_ack && last_word;

   // Shift both asynchronous HPS lines through the synchronizer chains.
   always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
      if (!DLY_RST_1) begin
         start_sync <= '0;
         req_sync   <= '0;
      end else begin
         start_sync <= {start_sync[SYNC_STAGES-2:0], bus.i_hps_start};
         req_sync   <= {req_sync[SYNC_STAGES-2:0], bus.i_hps_req};
      end
   end

   // Remember last synchronized levels for edge detection.
   always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
      if (!DLY_RST_1) begin
         start_prev <= 1'b0;
         req_prev   <= 1'b0;
      end else begin
         start_prev <= start_s;
         req_prev   <= req_s;
      end
   end

   // Next-state, pending and overrun decisions; start edges take priority.
   always_comb begin
      state_nxt = state;
      pend_nxt  = pending;
      ovr_set   = 1'b0;
      if (start_rise) begin
         // A request arriving with the start edge is discarded.
         state_nxt = WAIT_REQ;
         pend_nxt  = 1'b0;
      end else if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
            end
            WAIT_REQ: begin
               if (req_evt || pending) begin
                  state_nxt = FETCH;
                  // A fresh event while consuming the pending one stays queued.
                  pend_nxt  = req_evt && pending;
               end
            end
            FETCH: begin
               state_nxt = (RD_LAT > 1) ? WAIT_DATA : LATCH;
            end
            WAIT_DATA: begin
               if (lat_cnt <= 2'd1) begin
                  state_nxt = LATCH;
               end
            end
            LATCH: begin
               state_nxt = ACK;
            end
            ACK: begin
               state_nxt = last_word ? DONE : WAIT_REQ;
            end
            DONE: begin
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase

         // Requests arriving mid-service queue one deep; the frame's final ACK
         // discards them since nothing is left to fetch.
         if (req_evt && ((state == FETCH) || (state == WAIT_DATA) ||
                         (state == LATCH) || ((state == ACK) && !last_word))) begin
            if (pending) begin
               ovr_set = 1'b1;
            end else begin
               pend_nxt = 1'b1;
            end
         end
      end
   end

   // FSM state and the pending request flag.
   always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
      if (!DLY_RST_1) begin
         state   <= IDLE;
         pending <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pend_nxt;
      end
   end

   // Frame status flags: busy, done and sticky overrun.
   always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
      if (!DLY_RST_1) begin
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else if (start_rise) begin
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (abort || do_last) begin
            busy_q <= 1'b0;
         end
         if (do_last) begin
            done_q <= 1'b1;
         end
         if (ovr_set) begin
            overrun_q <= 1'b1;
         end
      end
   end

   // FIFO read latency countdown, armed on the strobe cycle.
   always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
      if (!DLY_RST_1) begin
         lat_cnt <= 2'd0;
      end else if (state == FETCH) begin
         lat_cnt <= LAT_LOAD;
      end else if ((state == WAIT_DATA) && (lat_cnt != 2'd0)) begin
         lat_cnt <= lat_cnt - 2'd1;
      end
   end

   // Row/column address of the next word to be latched.
   always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
      if (!DLY_RST_1) begin
         row_cnt <= 9'd0;
         col_cnt <= 6'd0;
      end else if (start_rise) begin
         row_cnt <= 9'd0;
         col_cnt <= 6'd0;
      end else if (do_latch) begin
         if (col_cnt == COL_LAST) begin
            col_cnt <= 6'd0;
            row_cnt <= row_cnt + 9'd1;
         end else begin
            col_cnt <= col_cnt + 6'd1;
         end
      end
   end

   // Capture the FIFO word with its address; held across abort and re-arm.
   always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
      if (!DLY_RST_1) begin
         word_q <= 16'd0;
         row_q  <= 9'd0;
         col_q  <= 6'd0;
      end else if (do_latch) begin
         word_q <= bus.i_fifo_rdata;
         row_q  <= row_cnt;
         col_q  <= col_cnt;
      end
   end

   // Toggle the acknowledge once the latched word is stable.
   always_ff @(posedge CLOCK_50 or negedge DLY_RST_1) begin
      if (!DLY_RST_1) begin
         ack_q <= 1'b0;
      end else if (do_ack) begin
         ack_q <= ~ack_q;
      end
   end

   // The strobe is decoded from FETCH so it lasts exactly one cycle; a word
   // read in a cycle that also aborts is simply not latched.
   assign bus.o_fifo_rd = (state == FETCH);
   assign bus.o_word    = word_q;
   assign bus.o_row     = row_q;
   assign bus.o_col     = col_q;
   assign bus.o_ack     = ack_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_done    = done_q;
   assign bus.o_overrun = overrun_q;
   assign bus.o_state   = state;

endmodule

// File: tb/tb_hps_frame_reader.sv
// Self-checking bench for hps_frame_reader: main instance with RD_LAT=1 and a
// second instance with RD_LAT=3 for the reset-during-WAIT_DATA scenario.
module tb_hps_frame_reader;

   logic CLOCK_50 = 1'b0;
   logic rst_n;
   logic rst_n3;

   // Free-running 50 MHz clock.
   always #10 CLOCK_50 = ~CLOCK_50;

   hps_frame_reader_if bus ();
   hps_frame_reader_if bus3 ();

   hps_frame_reader #(.RD_LAT(1)) dut (
      .CLOCK_50  (CLOCK_50),
      .DLY_RST_1 (rst_n),
      .bus       (bus)
   );

   hps_frame_reader #(.RD_LAT(3)) dut3 (
      .CLOCK_50  (CLOCK_50),
      .DLY_RST_1 (rst_n3),
      .bus       (bus3)
   );

   int          num_checks = 0;
   int          num_fail   = 0;
   int          rd_count   = 0;
   int          rd3_count  = 0;
   logic [15:0] fifo_q[$];
   logic [30:0] exp_q[$];
   logic [8:0]  m_row = 9'd0;
   logic [5:0]  m_col = 6'd0;
   logic        last_ack = 1'b0;

   // FIFO 1 model (RD_LAT=1): data appears after the strobe and stays valid
   // through the latch edge, then is replaced by garbage.
   initial begin
      int   hold;
      logic rd_prev;
      hold    = 0;
      rd_prev = 1'b0;
      bus.i_fifo_rdata = 16'h0BAD;
      forever begin
         @(negedge CLOCK_50);
         if (bus.o_fifo_rd === 1'b1) begin
            rd_count++;
            num_checks++;
            if (rd_prev) begin
               num_fail++;
               $display("FAIL fifo_rd_width: strobe high for 2+ cycles, required 1 cycle");
            end
            num_checks++;
            if (fifo_q.size() == 0) begin
               num_fail++;
               $display("FAIL unexpected_fifo_rd: strobe %0d with no request outstanding", rd_count);
               bus.i_fifo_rdata = 16'h0BAD;
            end else begin
               bus.i_fifo_rdata = fifo_q.pop_front();
            end
            hold = 1;
         end else if (hold != 0) begin
            hold = 0;
         end else begin
            bus.i_fifo_rdata = 16'h0BAD;
         end
         rd_prev = (bus.o_fifo_rd === 1'b1);
      end
   end

   // Scoreboard: each ack toggle pops one expected word/row/col.
   initial begin
      logic [30:0] exp_v;
      forever begin
         @(negedge CLOCK_50);
         if ((rst_n === 1'b1) && (bus.o_ack !== last_ack)) begin
            last_ack = bus.o_ack;
            num_checks++;
            if (exp_q.size() == 0) begin
               num_fail++;
               $display("FAIL unexpected_ack: ack toggled with empty expected queue (word %h)", bus.o_word);
            end else begin
               exp_v = exp_q.pop_front();
               if ({bus.o_word, bus.o_row, bus.o_col} !== exp_v) begin
                  num_fail++;
                  $display("FAIL word_addr: got word %h row %0d col %0d, expected word %h row %0d col %0d",
                           bus.o_word, bus.o_row, bus.o_col, exp_v[30:15], exp_v[14:6], exp_v[5:0]);
               end
            end
         end
      end
   end

   // Strobe counter for the RD_LAT=3 instance.
   initial begin
      forever begin
         @(negedge CLOCK_50);
         if (bus3.o_fifo_rd === 1'b1) rd3_count++;
      end
   end

   // Advance n clock edges, then step off the edge for driving.
   task automatic cyc(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   // Request one word that must be delivered; expectation queued now.
   task automatic push_req(input logic [15:0] w);
      fifo_q.push_back(w);
      exp_q.push_back({w, m_row, m_col});
      if (m_col == 6'd39) begin
         m_col = 6'd0;
         m_row = m_row + 9'd1;
      end else begin
         m_col = m_col + 6'd1;
      end
      bus.i_hps_req = ~bus.i_hps_req;
   endtask

   // Request edge that must be ignored or dropped.
   task automatic drop_req();
      bus.i_hps_req = ~bus.i_hps_req;
   endtask

   // Drop start (abort) then raise it (re-arm); model address restarts.
   task automatic arm();
      bus.i_hps_start = 1'b0;
      cyc(6);
      bus.i_hps_start = 1'b1;
      m_row = 9'd0;
      m_col = 6'd0;
      cyc(6);
   endtask

   // Wait for all queued words to be acknowledged, bounded.
   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < budget)) begin
         cyc(1);
         n++;
      end
      cyc(2);
      num_checks++;
      if (exp_q.size() != 0) begin
         num_fail++;
         $display("FAIL drain: %0d words still outstanding, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc(3);
      @(negedge CLOCK_50);
      num_checks++;
      if (bus.o_state !== 3'd0) begin
         num_fail++;
         $display("FAIL reset_state: got %0d, expected 0", bus.o_state);
      end
      num_checks++;
      if ({bus.o_fifo_rd, bus.o_word, bus.o_row, bus.o_col, bus.o_ack,
           bus.o_busy, bus.o_done, bus.o_overrun} !== 36'd0) begin
         num_fail++;
         $display("FAIL reset_outputs: rd %b word %h row %0d col %0d ack %b busy %b done %b ovr %b, expected all 0",
                  bus.o_fifo_rd, bus.o_word, bus.o_row, bus.o_col, bus.o_ack,
                  bus.o_busy, bus.o_done, bus.o_overrun);
      end
      cyc(1);
      rst_n = 1'b1;
      cyc(3);
   endtask

   task automatic test_basic();
      int r0;
      bus.i_hps_start = 1'b1;
      m_row = 9'd0;
      m_col = 6'd0;
      cyc(6);
      num_checks++;
      if ((bus.o_state !== 3'd1) || (bus.o_busy !== 1'b1)) begin
         num_fail++;
         $display("FAIL arm: state %0d busy %b, expected state 1 busy 1", bus.o_state, bus.o_busy);
      end
      r0 = rd_count;
      push_req(16'hA001);
      cyc(20);
      push_req(16'hA002);
      cyc(20);
      push_req(16'hA003);
      cyc(20);
      drain(50);
      num_checks++;
      if (rd_count - r0 !== 3) begin
         num_fail++;
         $display("FAIL basic_strobes: got %0d, expected 3", rd_count - r0);
      end
      num_checks++;
      if ({bus.o_word, bus.o_row, bus.o_col} !== {16'hA003, 9'd0, 6'd2}) begin
         num_fail++;
         $display("FAIL basic_last: word %h row %0d col %0d, expected A003 row 0 col 2",
                  bus.o_word, bus.o_row, bus.o_col);
      end
      num_checks++;
      if ((bus.o_ack !== 1'b1) || (bus.o_state !== 3'd1)) begin
         num_fail++;
         $display("FAIL basic_ack_state: ack %b state %0d, expected ack 1 state 1", bus.o_ack, bus.o_state);
      end
   endtask

   task automatic test_pending();
      int r0;
      r0 = rd_count;
      push_req(16'hB001);
      cyc(2);
      push_req(16'hB002);
      drain(50);
      num_checks++;
      if ((rd_count - r0 !== 2) || (bus.o_overrun !== 1'b0)) begin
         num_fail++;
         $display("FAIL pending_pair: strobes %0d overrun %b, expected 2 and 0", rd_count - r0, bus.o_overrun);
      end
      cyc(5);
      r0 = rd_count;
      push_req(16'hC001);
      cyc(1);
      push_req(16'hC002);
      cyc(1);
      drop_req();
      drain(50);
      cyc(10);
      num_checks++;
      if ((rd_count - r0 !== 2) || (bus.o_overrun !== 1'b1)) begin
         num_fail++;
         $display("FAIL overrun: strobes %0d overrun %b, expected 2 and 1", rd_count - r0, bus.o_overrun);
      end
      num_checks++;
      if ({bus.o_row, bus.o_col, bus.o_state} !== {9'd0, 6'd6, 3'd1}) begin
         num_fail++;
         $display("FAIL overrun_addr: row %0d col %0d state %0d, expected row 0 col 6 state 1",
                  bus.o_row, bus.o_col, bus.o_state);
      end
   endtask

   task automatic test_abort();
      int r0;
      arm();
      num_checks++;
      if ({bus.o_overrun, bus.o_done, bus.o_busy} !== 3'b001) begin
         num_fail++;
         $display("FAIL rearm_flags: ovr %b done %b busy %b, expected 0 0 1",
                  bus.o_overrun, bus.o_done, bus.o_busy);
      end
      for (int i = 0; i < 84; i++) begin
         push_req(16'h1000 + 16'(i));
         cyc(4);
      end
      drain(50);
      bus.i_hps_start = 1'b0;
      cyc(6);
      num_checks++;
      if ({bus.o_state, bus.o_busy} !== {3'd0, 1'b0}) begin
         num_fail++;
         $display("FAIL abort_state: state %0d busy %b, expected 0 0", bus.o_state, bus.o_busy);
      end
      num_checks++;
      if ({bus.o_word, bus.o_row, bus.o_col} !== {16'h1053, 9'd2, 6'd3}) begin
         num_fail++;
         $display("FAIL abort_hold: word %h row %0d col %0d, expected 1053 row 2 col 3",
                  bus.o_word, bus.o_row, bus.o_col);
      end
      r0 = rd_count;
      drop_req();
      cyc(10);
      num_checks++;
      if (rd_count - r0 !== 0) begin
         num_fail++;
         $display("FAIL idle_ignore: strobes %0d, expected 0", rd_count - r0);
      end
      bus.i_hps_start = 1'b1;
      m_row = 9'd0;
      m_col = 6'd0;
      cyc(6);
      push_req(16'h2000);
      drain(50);
      num_checks++;
      if ({bus.o_word, bus.o_row, bus.o_col} !== {16'h2000, 9'd0, 6'd0}) begin
         num_fail++;
         $display("FAIL restart_addr: word %h row %0d col %0d, expected 2000 row 0 col 0",
                  bus.o_word, bus.o_row, bus.o_col);
      end
   endtask

   task automatic test_full_frame();
      int r0;
      arm();
      r0 = rd_count;
      for (int i = 0; i < 19200; i++) begin
         push_req(16'($urandom_range(0, 65535)));
         cyc(4);
      end
      drain(100);
      num_checks++;
      if (rd_count - r0 !== 19200) begin
         num_fail++;
         $display("FAIL frame_strobes: got %0d, expected 19200", rd_count - r0);
      end
      num_checks++;
      if ({bus.o_row, bus.o_col} !== {9'd479, 6'd39}) begin
         num_fail++;
         $display("FAIL frame_last_addr: row %0d col %0d, expected row 479 col 39", bus.o_row, bus.o_col);
      end
      num_checks++;
      if ({bus.o_done, bus.o_busy, bus.o_overrun, bus.o_state} !== {1'b1, 1'b0, 1'b0, 3'd6}) begin
         num_fail++;
         $display("FAIL frame_flags: done %b busy %b ovr %b state %0d, expected 1 0 0 6",
                  bus.o_done, bus.o_busy, bus.o_overrun, bus.o_state);
      end
      r0 = rd_count;
      drop_req();
      cyc(10);
      num_checks++;
      if ((rd_count - r0 !== 0) || (bus.o_state !== 3'd6)) begin
         num_fail++;
         $display("FAIL done_ignore: strobes %0d state %0d, expected 0 and 6", rd_count - r0, bus.o_state);
      end
   endtask

   task automatic test_coincident();
      int r0;
      bus.i_hps_start = 1'b0;
      cyc(6);
      num_checks++;
      if ((bus.o_state !== 3'd6) || (bus.o_done !== 1'b1)) begin
         num_fail++;
         $display("FAIL done_hold: state %0d done %b, expected 6 and 1", bus.o_state, bus.o_done);
      end
      r0 = rd_count;
      bus.i_hps_start = 1'b1;
      drop_req();
      cyc(8);
      num_checks++;
      if (rd_count - r0 !== 0) begin
         num_fail++;
         $display("FAIL coincident_strobe: strobes %0d, expected 0", rd_count - r0);
      end
      num_checks++;
      if ({bus.o_state, bus.o_done, bus.o_busy} !== {3'd1, 1'b0, 1'b1}) begin
         num_fail++;
         $display("FAIL coincident_state: state %0d done %b busy %b, expected 1 0 1",
                  bus.o_state, bus.o_done, bus.o_busy);
      end
   endtask

   task automatic test_reset_wait_data();
      int   r0;
      int   n;
      logic seen;
      rst_n3 = 1'b1;
      bus3.i_hps_start = 1'b1;
      cyc(6);
      bus3.i_hps_req = ~bus3.i_hps_req;
      cyc(15);
      num_checks++;
      if ({bus3.o_word, bus3.o_ack} !== {16'h5A5A, 1'b1}) begin
         num_fail++;
         $display("FAIL lat3_word: word %h ack %b, expected 5A5A and 1", bus3.o_word, bus3.o_ack);
      end
      bus3.i_hps_req = ~bus3.i_hps_req;
      seen = 1'b0;
      n = 0;
      while (!seen && (n < 20)) begin
         @(negedge CLOCK_50);
         seen = (bus3.o_state === 3'd3);
         n++;
      end
      num_checks++;
      if (!seen) begin
         num_fail++;
         $display("FAIL lat3_wait_data: state %0d, expected to reach 3", bus3.o_state);
      end
      rst_n3 = 1'b0;
      #1;
      num_checks++;
      if ({bus3.o_state, bus3.o_fifo_rd, bus3.o_word, bus3.o_row, bus3.o_col, bus3.o_ack,
           bus3.o_busy, bus3.o_done, bus3.o_overrun} !== 39'd0) begin
         num_fail++;
         $display("FAIL lat3_async_reset: state %0d word %h ack %b busy %b, expected all 0",
                  bus3.o_state, bus3.o_word, bus3.o_ack, bus3.o_busy);
      end
      cyc(1);
      bus3.i_hps_start = 1'b0;
      cyc(2);
      rst_n3 = 1'b1;
      r0 = rd3_count;
      cyc(10);
      bus3.i_hps_req = ~bus3.i_hps_req;
      cyc(10);
      num_checks++;
      if ((rd3_count - r0 !== 0) || (bus3.o_state !== 3'd0)) begin
         num_fail++;
         $display("FAIL lat3_post_reset: strobes %0d state %0d, expected 0 and 0", rd3_count - r0, bus3.o_state);
      end
      bus3.i_hps_start = 1'b1;
      cyc(6);
      bus3.i_hps_req = ~bus3.i_hps_req;
      cyc(15);
      num_checks++;
      if ((rd3_count - r0 !== 1) || ({bus3.o_word, bus3.o_row, bus3.o_col} !== {16'h5A5A, 9'd0, 6'd0})) begin
         num_fail++;
         $display("FAIL lat3_rearm: strobes %0d word %h row %0d col %0d, expected 1 5A5A 0 0",
                  rd3_count - r0, bus3.o_word, bus3.o_row, bus3.o_col);
      end
   endtask

   // Sequence all scenarios, then report.
   initial begin
      rst_n  = 1'b0;
      rst_n3 = 1'b0;
      bus.i_hps_start   = 1'b0;
      bus.i_hps_req     = 1'b0;
      bus3.i_hps_start  = 1'b0;
      bus3.i_hps_req    = 1'b0;
      bus3.i_fifo_rdata = 16'h5A5A;
      test_reset();
      test_basic();
      test_pending();
      test_abort();
      test_full_frame();
      test_coincident();
      test_reset_wait_data();
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
